// File: rtl/cfg_regbank_if.sv
// fx bus bundle between the bus bridge (master) and a register bank (slave).
interface cfg_regbank_if #(
  parameter int DW = 8
);
  logic          fx_wr;
  logic [21:0]   fx_waddr;
  logic [DW-1:0] fx_data;
  logic          fx_rd;
  logic [21:0]   fx_raddr;
  logic [DW-1:0] fx_q;

  modport master (
    output fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
    input  fx_q
  );

  modport slave (
    input  fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
    output fx_q
  );
endinterface

// File: rtl/cfg_regbank.sv
// Configuration/status register bank on one fx device slot: control regs, sticky W1C status.
// Optional shadow/commit staging is enabled by defining CFG_REGBANK_SHADOW_EN.
module cfg_regbank #(
  parameter logic [5:0]           DEV_ID  = 6'h1,
  parameter logic [15:0]          BASE    = 16'h0080,
  parameter int                   DW      = 8,
  parameter int                   NREG    = 8,
  parameter int                   NSTAT   = 2,
  parameter logic [NREG*DW-1:0]   RST_VAL = {8'h87, 8'h86, 8'h85, 8'h84,
                                             8'h83, 8'h82, 8'h81, 8'h80}
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  cfg_regbank_if.slave          fx,
  output logic [NREG*DW-1:0]    cfg_q,
  output logic [NREG-1:0]       cfg_upd,
  input  logic [NSTAT*DW-1:0]   sts_set,
  output logic [NSTAT*DW-1:0]   sts_q
);

  localparam logic [15:0] CMT_OFF = 16'(NREG + NSTAT);

  logic                  now_wr;
  logic                  now_rd;
  logic [15:0]           woff;
  logic [15:0]           roff;
  logic [NREG*DW-1:0]    active;
  logic [NREG*DW-1:0]    active_nxt;
  logic [NREG-1:0]       upd_nxt;
  logic [NSTAT*DW-1:0]   sticky;
  logic [NSTAT*DW-1:0]   sticky_nxt;
  logic [NREG*DW-1:0]    ctl_view;
  logic [DW-1:0]         rdata;

  assign now_wr = fx.fx_wr & (fx.fx_waddr[21:16] == DEV_ID);
  assign now_rd = fx.fx_rd & (fx.fx_raddr[21:16] == DEV_ID);
  // Addresses below BASE wrap to large offsets and fall into the unmapped range.
  assign woff   = fx.fx_waddr[15:0] - BASE;
  assign roff   = fx.fx_raddr[15:0] - BASE;

  assign cfg_q  = active;
  assign sts_q  = sticky;

`ifdef CFG_REGBANK_SHADOW_EN
  logic [NREG*DW-1:0] shadow;
  logic [NREG*DW-1:0] shadow_nxt;
  logic               pending;
  logic               pending_nxt;

  assign ctl_view = shadow;

  always_comb begin
    shadow_nxt  = shadow;
    pending_nxt = pending;
    active_nxt  = active;
    upd_nxt     = '0;
    for (int i = 0; i < NREG; i++) begin
      if (now_wr && woff == 16'(i)) begin
        shadow_nxt[i*DW +: DW] = fx.fx_data;
        pending_nxt            = 1'b1;
      end
    end
    if (now_wr && woff == CMT_OFF && fx.fx_data[0]) begin
      active_nxt  = shadow;
      upd_nxt     = '1;
      pending_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      shadow  <= RST_VAL;
      pending <= 1'b0;
    end else begin
      shadow  <= shadow_nxt;
      pending <= pending_nxt;
    end
  end
`else
  assign ctl_view = active;

  always_comb begin
    active_nxt = active;
    upd_nxt    = '0;
    for (int i = 0; i < NREG; i++) begin
      if (now_wr && woff == 16'(i)) begin
        active_nxt[i*DW +: DW] = fx.fx_data;
        upd_nxt[i]             = 1'b1;
      end
    end
  end
`endif

  // Set is OR'ed in after the clear so a same-cycle event is never lost.
  always_comb begin
    sticky_nxt = sticky;
    for (int j = 0; j < NSTAT; j++) begin
      if (now_wr && woff == 16'(NREG + j))
        sticky_nxt[j*DW +: DW] = (sticky[j*DW +: DW] & ~fx.fx_data) | sts_set[j*DW +: DW];
      else
        sticky_nxt[j*DW +: DW] = sticky[j*DW +: DW] | sts_set[j*DW +: DW];
    end
  end

  // Read mux works on current register values, so a same-cycle write is not visible.
  always_comb begin
    rdata = '0;
    if (now_rd) begin
      rdata = DW'(8'h55);
      for (int i = 0; i < NREG; i++)
        if (roff == 16'(i)) rdata = ctl_view[i*DW +: DW];
      for (int j = 0; j < NSTAT; j++)
        if (roff == 16'(NREG + j)) rdata = sticky[j*DW +: DW];
`ifdef CFG_REGBANK_SHADOW_EN
      if (roff == CMT_OFF) rdata = DW'(pending);
`endif
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      active  <= RST_VAL;
      sticky  <= '0;
      cfg_upd <= '0;
      fx.fx_q <= '0;
    end else begin
      active  <= active_nxt;
      sticky  <= sticky_nxt;
      cfg_upd <= upd_nxt;
      fx.fx_q <= rdata;
    end
  end

endmodule

// File: tb/tb_cfg_regbank.sv
// Directed table-driven bench for cfg_regbank (default parameters, either build of CFG_REGBANK_SHADOW_EN).
module tb_cfg_regbank;

  localparam logic [63:0] RV = 64'h8786_8584_8382_8180;

  logic        clk_sys = 1'b0;
  logic        rst     = 1'b1;
  logic [63:0] cfg_q;
  logic [7:0]  cfg_upd;
  logic [15:0] sts_set = '0;
  logic [15:0] sts_q;

  int checks   = 0;
  int failures = 0;

  cfg_regbank_if #(.DW(8)) fx ();

  cfg_regbank dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .fx      (fx),
    .cfg_q   (cfg_q),
    .cfg_upd (cfg_upd),
    .sts_set (sts_set),
    .sts_q   (sts_q)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    string       name;
    logic        wr;
    logic [21:0] waddr;
    logic [7:0]  wdata;
    logic        rd;
    logic [21:0] raddr;
    logic [15:0] sset;
    logic [7:0]  exp_q;
    logic [15:0] exp_sts;
    logic [7:0]  exp_upd;
    logic [63:0] exp_cfg;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(string nm, logic wr, logic [21:0] wa, logic [7:0] wd,
                              logic rd, logic [21:0] ra, logic [15:0] ss,
                              logic [7:0] q, logic [15:0] st);
    vec_t v;
    v.name = nm; v.wr = wr; v.waddr = wa; v.wdata = wd; v.rd = rd; v.raddr = ra;
    v.sset = ss; v.exp_q = q; v.exp_sts = st; v.exp_upd = 8'h00; v.exp_cfg = RV;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(logic wr, logic [21:0] wa, logic [7:0] wd,
                       logic rd, logic [21:0] ra, logic [15:0] ss);
    fx.fx_wr = wr; fx.fx_waddr = wa; fx.fx_data = wd;
    fx.fx_rd = rd; fx.fx_raddr = ra; sts_set = ss;
  endtask

  task automatic cyc();
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic step(logic wr, logic [21:0] wa, logic [7:0] wd,
                      logic rd, logic [21:0] ra, logic [15:0] ss);
    drive(wr, wa, wd, rd, ra, ss);
    cyc();
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_fx_q"},    {56'h0, fx.fx_q}, 64'h0);
    chk({tag, "_sts_q"},   {48'h0, sts_q},   64'h0);
    chk({tag, "_cfg_upd"}, {56'h0, cfg_upd}, 64'h0);
    chk({tag, "_cfg_q"},   cfg_q,            RV);
  endtask

  initial begin
    //            name          wr  waddr       wd     rd  raddr       sset      q      sts
    vt[0]  = mk("rd_80",        0, 22'h0, 8'h00,       1, 22'h010080, 16'h0000, 8'h80, 16'h0000);
    vt[1]  = mk("idle_q0",      0, 22'h0, 8'h00,       0, 22'h010080, 16'h0000, 8'h00, 16'h0000);
    vt[2]  = mk("rd_81",        0, 22'h0, 8'h00,       1, 22'h010081, 16'h0000, 8'h81, 16'h0000);
    vt[3]  = mk("rd_87_b2b",    0, 22'h0, 8'h00,       1, 22'h010087, 16'h0000, 8'h87, 16'h0000);
    vt[4]  = mk("rd_unmap_90",  0, 22'h0, 8'h00,       1, 22'h010090, 16'h0000, 8'h55, 16'h0000);
    vt[5]  = mk("rd_wrong_dev", 0, 22'h0, 8'h00,       1, 22'h020080, 16'h0000, 8'h00, 16'h0000);
    vt[6]  = mk("rd_below_base",0, 22'h0, 8'h00,       1, 22'h01007F, 16'h0000, 8'h55, 16'h0000);
    vt[7]  = mk("sts_set_11",   0, 22'h0, 8'h00,       0, 22'h0,      16'h0011, 8'h00, 16'h0011);
    vt[8]  = mk("w1c_set_wins", 1, 22'h010088, 8'h01,  0, 22'h0,      16'h0001, 8'h00, 16'h0011);
    vt[9]  = mk("rd_sts0_11",   0, 22'h0, 8'h00,       1, 22'h010088, 16'h0000, 8'h11, 16'h0011);
    vt[10] = mk("w1c_clr_10",   1, 22'h010088, 8'h10,  0, 22'h0,      16'h0000, 8'h00, 16'h0001);
    vt[11] = mk("rd_sts0_01",   0, 22'h0, 8'h00,       1, 22'h010088, 16'h0000, 8'h01, 16'h0001);
    vt[12] = mk("sts_set_s1",   0, 22'h0, 8'h00,       0, 22'h0,      16'h8000, 8'h00, 16'h8001);
    vt[13] = mk("rd_sts1_80",   0, 22'h0, 8'h00,       1, 22'h010089, 16'h0000, 8'h80, 16'h8001);
    vt[14] = mk("sts1_rw_same", 1, 22'h010089, 8'hFF,  1, 22'h010089, 16'h0000, 8'h80, 16'h0001);
    vt[15] = mk("wr_wrong_dev", 1, 22'h020081, 8'h00,  0, 22'h0,      16'h0000, 8'h00, 16'h0001);
    vt[16] = mk("wr_unmap_8b",  1, 22'h01008B, 8'h12,  0, 22'h0,      16'h0000, 8'h00, 16'h0001);

    drive(0, 22'h0, 8'h00, 0, 22'h0, 16'h0);
    cyc();
    cyc();
    chk_reset_outputs("in_reset");
    rst = 1'b0;
    cyc();
    chk_reset_outputs("after_reset");

    for (int k = 0; k < 17; k++) begin
      drive(vt[k].wr, vt[k].waddr, vt[k].wdata, vt[k].rd, vt[k].raddr, vt[k].sset);
      cyc();
      chk({vt[k].name, "_q"},   {56'h0, fx.fx_q}, {56'h0, vt[k].exp_q});
      chk({vt[k].name, "_sts"}, {48'h0, sts_q},   {48'h0, vt[k].exp_sts});
      chk({vt[k].name, "_upd"}, {56'h0, cfg_upd}, {56'h0, vt[k].exp_upd});
      chk({vt[k].name, "_cfg"}, cfg_q,            vt[k].exp_cfg);
    end
    step(0, 22'h0, 8'h00, 0, 22'h0, 16'h0);
    chk("q_one_cycle", {56'h0, fx.fx_q}, 64'h0);

`ifdef CFG_REGBANK_SHADOW_EN
    step(1, 22'h010081, 8'hA5, 0, 22'h0, 16'h0);
    chk("shd_cfg_held", {56'h0, cfg_q[15:8]}, 64'h81);
    chk("shd_no_upd",   {56'h0, cfg_upd},     64'h0);
    step(0, 22'h0, 8'h00, 1, 22'h01008A, 16'h0);
    chk("shd_pending_1", {56'h0, fx.fx_q}, 64'h01);
    step(0, 22'h0, 8'h00, 1, 22'h010081, 16'h0);
    chk("shd_rd_shadow", {56'h0, fx.fx_q}, 64'hA5);
    step(1, 22'h01008A, 8'h00, 0, 22'h0, 16'h0);
    chk("shd_cmt0_noop_cfg", {56'h0, cfg_q[15:8]}, 64'h81);
    chk("shd_cmt0_noop_upd", {56'h0, cfg_upd},     64'h0);
    step(1, 22'h01008A, 8'h01, 0, 22'h0, 16'h0);
    chk("shd_commit_cfg", cfg_q,              64'h8786_8584_8382_A580);
    chk("shd_commit_upd", {56'h0, cfg_upd},   64'hFF);
    step(0, 22'h0, 8'h00, 1, 22'h01008A, 16'h0);
    chk("shd_upd_pulse", {56'h0, cfg_upd}, 64'h0);
    chk("shd_pending_0", {56'h0, fx.fx_q}, 64'h00);
`else
    step(1, 22'h010083, 8'h3C, 0, 22'h0, 16'h0);
    chk("dir_cfg_83",  {56'h0, cfg_q[31:24]}, 64'h3C);
    chk("dir_upd_83",  {56'h0, cfg_upd},      64'h08);
    step(1, 22'h010084, 8'hEE, 1, 22'h010084, 16'h0);
    chk("dir_upd_pulse",  {56'h0, cfg_upd},    64'h10);
    chk("dir_rw_pre",     {56'h0, fx.fx_q},    64'h84);
    chk("dir_cfg_84",     cfg_q,               64'h8786_85EE_3C82_8180);
    step(0, 22'h0, 8'h00, 1, 22'h010084, 16'h0);
    chk("dir_rd_post",    {56'h0, fx.fx_q},    64'hEE);
    chk("dir_upd_clear",  {56'h0, cfg_upd},    64'h0);
    step(1, 22'h01008A, 8'h01, 0, 22'h0, 16'h0);
    chk("dir_cmt_ign_upd", {56'h0, cfg_upd}, 64'h0);
    step(0, 22'h0, 8'h00, 1, 22'h01008A, 16'h0);
    chk("dir_cmt_unmap",  {56'h0, fx.fx_q},  64'h55);
`endif

    step(0, 22'h0, 8'h00, 1, 22'h010080, 16'h0404);
    chk("pre_rst_q",   {56'h0, fx.fx_q}, 64'h80);
    chk("pre_rst_sts", {48'h0, sts_q},   64'h0405);
    rst = 1'b1;
    drive(1, 22'h010080, 8'h99, 0, 22'h0, 16'h0);
    #1;
    chk_reset_outputs("rst_async");
    cyc();
    chk_reset_outputs("rst_held");
    rst = 1'b0;
    step(0, 22'h0, 8'h00, 1, 22'h010080, 16'h0);
    chk("rst_wr_lost_cfg", cfg_q,            RV);
    chk("rst_wr_lost_rd",  {56'h0, fx.fx_q}, 64'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
